// File: rtl/top10_stream_out.sv
// ----------------------------------------------------------------------------
// top10_stream_out
//
// Purpose:
//   Downstream reader for the top-10 sorter. A start pulse snapshots the flat
//   sorted value vector and the matching node-ID vector. The block then streams
//   one (rank, id, value) entry per accepted beat, rank 0 (largest value) first.
//
// Parameters:
//   DATA_WIDTH  width of one rank value
//   ID_WIDTH    width of one node ID
//   NUM_TOP     entries per frame (1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      pulse: array_in/id_in hold a finished sort result
//   array_in   sorted values, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   id_in      node IDs, entry i at [i*ID_WIDTH +: ID_WIDTH]
//   out_valid  entry on out_* is valid
//   out_ready  consumer accepts the entry this cycle
//   out_data   value of current entry
//   out_id     node ID of current entry
//   out_rank   index of current entry in the frame (0 = top)
//   out_last   current entry is the final one of the frame
//   busy       frame in progress (start ignored)
//   done       one-cycle pulse after the final entry is accepted
//
// Build option:
//   TOP10_SKIP_ZERO_EN - when defined, zero-valued entries are not emitted.
//   The frame ends at the first zero. An all-zero frame still pulses done
//   without ever raising out_valid.
//
// Handshake:
//   A beat occurs when out_valid and out_ready are both high at a rising edge.
//   While out_valid is high and no beat occurs, every out_* signal holds.
//   out_ready has no effect while out_valid is low.
//   When out_valid is low, out_data/out_id/out_rank/out_last are all zero.
//
// Debug: the FSM state register is 'state'. It is of type state_t and is
//   visible hierarchically for checkers.
// ----------------------------------------------------------------------------
module top10_stream_out #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 6,
    parameter int NUM_TOP    = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [DATA_WIDTH*NUM_TOP-1:0]  array_in,
    input  logic [ID_WIDTH*NUM_TOP-1:0]    id_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic [3:0]                     out_rank,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

`ifdef TOP10_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    localparam logic [3:0] LAST_IDX   = 4'(NUM_TOP - 1);
    // Offset of entry 1 in array_in. It falls back to entry 0 for a
    // single-entry frame so that the slice is always in range.
    localparam int         SECOND_OFS = (NUM_TOP > 1) ? DATA_WIDTH : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             index;

    // Snapshot depth is fixed at 16 so that the 4-bit lookahead index
    // never leaves the array. Slots at or above NUM_TOP stay zero.
    logic [DATA_WIDTH-1:0]  snap_data [16];
    logic [ID_WIDTH-1:0]    snap_id   [16];

    // Next entry taken from the snapshot, used on a non-final beat.
    logic [3:0]             nxt_idx;
    logic [3:0]             nxt2_idx;
    logic                   nxt_last;

    // First entry taken straight from the inputs in the start cycle.
    logic [DATA_WIDTH-1:0]  first_data;
    logic [DATA_WIDTH-1:0]  second_data;
    logic [ID_WIDTH-1:0]    first_id;
    logic                   first_valid;
    logic                   first_last;

    always_comb begin
        nxt_idx  = index + 4'd1;
        nxt2_idx = index + 4'd2;
        // nxt2_idx can only wrap when nxt_idx is already the final index.
        nxt_last = (nxt_idx == LAST_IDX) ||
                   (SKIP_ZERO && (snap_data[nxt2_idx] == '0));
    end

    always_comb begin
        first_data  = array_in[0 +: DATA_WIDTH];
        second_data = array_in[SECOND_OFS +: DATA_WIDTH];
        first_id    = id_in[0 +: ID_WIDTH];
        first_valid = !(SKIP_ZERO && (first_data == '0));
        first_last  = (NUM_TOP == 1) || (SKIP_ZERO && (second_data == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            index     <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_rank  <= 4'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                snap_data[i] <= '0;
                snap_id[i]   <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NUM_TOP; i++) begin
                            snap_data[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
                            snap_id[i]   <= id_in[i*ID_WIDTH +: ID_WIDTH];
                        end
                        index     <= 4'd0;
                        state     <= ST_SEND;
                        busy      <= 1'b1;
                        // Outputs are registered, so entry 0 is presented
                        // from the live inputs in the same edge as the capture.
                        out_valid <= first_valid;
                        out_data  <= first_valid ? first_data : '0;
                        out_id    <= first_valid ? first_id   : '0;
                        out_rank  <= 4'd0;
                        out_last  <= first_valid && first_last;
                    end
                end

                ST_SEND: begin
                    if (!out_valid) begin
                        // Only an all-zero frame with zero skipping reaches
                        // this branch: nothing is emitted, but done still pulses.
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_id    <= '0;
                            out_rank  <= 4'd0;
                            out_last  <= 1'b0;
                        end else begin
                            index    <= nxt_idx;
                            out_data <= snap_data[nxt_idx];
                            out_id   <= snap_id[nxt_idx];
                            out_rank <= nxt_idx;
                            out_last <= nxt_last;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    index <= 4'd0;
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top10_stream_out.sv
// ----------------------------------------------------------------------------
// tb_top10_stream_out
//
// Purpose:
//   Self-checking bench for top10_stream_out.
//
// Structure:
//   - Stimulus pushes the expected {last, rank, id, data} entries of each
//     frame into exp_q.
//   - A negedge monitor pops and compares them on every accepted beat.
//   - The monitor also checks output hold under stall, zeroed outputs while
//     idle, and the timing of the done pulse.
//
// Build option:
//   TOP10_SKIP_ZERO_EN selects the zero-skipping expectations.
// ----------------------------------------------------------------------------
module tb_top10_stream_out;

    localparam int DW = 16;
    localparam int IW = 6;
    localparam int NT = 10;
    localparam int EW = 1 + 4 + IW + DW;

`ifdef TOP10_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DW*NT-1:0]  array_in;
    logic [IW*NT-1:0]  id_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic [3:0]        out_rank;
    logic              out_last;
    logic              busy;
    logic              done;

    int                chk_cnt = 0;
    int                pass_cnt = 0;
    logic [EW-1:0]     exp_q[$];

    logic [DW-1:0]     val_tab [4][NT];
    logic [IW-1:0]     id_tab  [4][NT];

    // 0: always ready, 1: ready pattern 1,0,0 repeating, 3: driven by main
    int                ready_mode = 3;
    int                cyc = 0;
    logic              empty_due = 1'b0;

    logic              last_beat_d = 1'b0;
    logic              prev_stall = 1'b0;
    logic [EW-1:0]     prev_ent;
    logic [EW-1:0]     mon_ent;

    top10_stream_out #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .NUM_TOP    (NT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .array_in  (array_in),
        .id_in     (id_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_rank  (out_rank),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- common compare ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_inputs(input int f);
        for (int i = 0; i < NT; i++) begin
            array_in[i*DW +: DW] = val_tab[f][i];
            id_in[i*IW +: IW]    = id_tab[f][i];
        end
    endtask

    // Push the frame's expected entries. Returns whether entry 0 is emitted.
    task automatic push_frame(input int f, output logic first_vld);
        logic lst;
        first_vld = !(SKIP && (val_tab[f][0] == '0));
        for (int i = 0; i < NT; i++) begin
            if (SKIP && (val_tab[f][i] == '0)) break;
            lst = (i == NT - 1);
            if (SKIP && (i < NT - 1)) begin
                if (val_tab[f][i+1] == '0) lst = 1'b1;
            end
            exp_q.push_back({lst, 4'(i), id_tab[f][i], val_tab[f][i]});
        end
    endtask

    // Called at posedge+1. Returns at posedge+1 of the cycle after start is sampled.
    task automatic run_frame(input int f);
        logic fv;
        push_frame(f, fv);
        load_inputs(f);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_latency_valid", out_valid, fv);
        check("start_busy", busy, 1'b1);
        if (!fv) begin
            // Empty frame: SEND this cycle, DONE (with the done pulse) in the next.
            @(posedge clk); #1;
            empty_due = 1'b1;
            @(posedge clk); #1;
            empty_due = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        check("frame_busy_cleared", busy, 1'b0);
        check("frame_drained", exp_q.size(), 0);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (ready_mode == 0)      out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ((cyc % 3) == 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_beat_d = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                mon_ent = {out_last, out_rank, out_id, out_data};
                if (done || last_beat_d || empty_due)
                    check("done_timing", done, last_beat_d || empty_due);
                if (prev_stall)
                    check("stall_hold", {out_valid, mon_ent}, {1'b1, prev_ent});
                if (!out_valid)
                    check("idle_outputs_zero", mon_ent, '0);
                last_beat_d = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_beat: got %0h expected none", mon_ent);
                    end else begin
                        check("beat_entry", mon_ent, exp_q.pop_front());
                    end
                    last_beat_d = out_last;
                end
                prev_stall = out_valid && !out_ready;
                prev_ent   = mon_ent;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NT; i++) begin
            val_tab[0][i] = 16'(100 - 10 * i);            // 100,90..10
            id_tab[0][i]  = 6'(i);                        // 0..9
            val_tab[1][i] = 16'(1000 - 97 * i);           // 1000,903..127
            id_tab[1][i]  = 6'(63 - i);                   // 63..54
            val_tab[2][i] = (i < 3) ? 16'(50 - 10 * i) : 16'd0;  // 50,40,30,0..
            id_tab[2][i]  = 6'(20 + i);
            val_tab[3][i] = 16'd0;
            id_tab[3][i]  = 6'(1 + i);
        end

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        array_in = '0; id_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_fields", {out_last, out_rank, out_id, out_data}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // out_ready while idle has no effect
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_no_valid", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Full frame, consumer always ready
        ready_mode = 0;
        run_frame(0);
        wait_idle();

        // Same frame with stalls
        ready_mode = 1;
        run_frame(0);
        wait_idle();

        // Second start during SEND with different data is ignored
        ready_mode = 1;
        run_frame(0);
        repeat (2) @(posedge clk);
        #1;
        load_inputs(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_busy", busy, 1'b1);
        wait_idle();

        // Back-to-back frames: new start in the cycle right after done
        ready_mode = 0;
        run_frame(1);
        wait_done();
        @(posedge clk); #1;
        run_frame(0);
        check("b2b_first_rank", out_rank, 4'd0);
        wait_idle();

        // Reset mid-frame after four beats
        ready_mode = 3;
        out_ready = 1'b1;
        run_frame(0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_rank", out_rank, 4'd4);
        rst = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_no_done", done, 1'b0);
        ready_mode = 0;
        run_frame(0);
        check("restart_rank", out_rank, 4'd0);
        check("restart_data", out_data, 16'd100);
        wait_idle();

        // Frames containing zeros (truncated when zero skipping is built in)
        run_frame(2);
        wait_idle();
        run_frame(3);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
